// File: rtl/frame_sequencer_pkg.sv
// Shared types for the frame sequencer: FSM states, button bit positions
// and the frame counter width.
package utils;

  typedef enum logic [1:0] {
    SPAWN   = 2'd0,
    RUN     = 2'd1,
    DEAD    = 2'd2,
    ADVANCE = 2'd3
  } frame_state_t;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_JUMP  = 4;
  localparam int BTN_DASH  = 5;
  localparam int BTN_W     = 6;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_sequencer_btn_capture.sv
// Button sampling: held buttons latched on consume, sticky jump/dash
// press flags set on rising edges and handed out on consume.
module btn_capture
  import utils::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btn_i,
  input  logic             consume_i,
  input  logic             clear_i,
  output logic [BTN_W-1:0] btn_o,
  output logic [1:0]       btnp_o
);

  logic [1:0]       prev_q, prev_d;
  logic [1:0]       flags_q, flags_d;
  logic [BTN_W-1:0] btn_q, btn_d;
  logic [1:0]       btnp_q, btnp_d;
  logic [1:0]       pair;
  logic [1:0]       rise;

  always_comb begin
    pair    = {btn_i[BTN_DASH], btn_i[BTN_JUMP]};
    rise    = pair & ~prev_q;
    prev_d  = pair;
    btn_d   = btn_q;
    btnp_d  = btnp_q;
    flags_d = flags_q;
    if (consume_i) begin
      btn_d  = btn_i;
      btnp_d = flags_q;
    end
    if (consume_i || clear_i) begin
      flags_d = '0;
    end
    // an edge coinciding with the clear lands in the next frame
    flags_d = flags_d | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      flags_q <= '0;
      btn_q   <= '0;
      btnp_q  <= '0;
    end else begin
      prev_q  <= prev_d;
      flags_q <= flags_d;
      btn_q   <= btn_d;
      btnp_q  <= btnp_d;
    end
  end

  assign btn_o  = btn_q;
  assign btnp_o = btnp_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: frame tick divider, spawn/run/dead/advance FSM and
// room counter. Define FRAME_STEP_EN to tick on step_i rising edges instead.
module frame_sequencer
  import utils::*;
#(
  parameter int CLK_PER_FRAME = 833334,
  parameter int NUM_ROOMS     = 31,
  parameter int DEATH_FRAMES  = 15,
  localparam int ROOM_W = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BTN_W-1:0]       btn_i,
  input  logic                   exit_i,
  input  logic                   dead_i,
`ifdef FRAME_STEP_EN
  input  logic                   step_i,
`endif
  output logic                   update_o,
  output logic                   player_rst_o,
  output logic [BTN_W-1:0]       btn_o,
  output logic [1:0]             btnp_o,
  output logic [ROOM_W-1:0]      room_o,
  output logic [FRAME_CNT_W-1:0] frame_o
);

  localparam int DIV_W =
    (CLK_PER_FRAME > 1) ? $clog2(CLK_PER_FRAME) : 1;
  localparam int DTH_W = $clog2(DEATH_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_PER_FRAME - 1);
  localparam logic [ROOM_W-1:0] ROOM_MAX = ROOM_W'(NUM_ROOMS - 1);
  localparam logic [DTH_W-1:0]  DTH_MAX  = DTH_W'(DEATH_FRAMES - 1);

  frame_state_t state_q, state_d;

  logic [DIV_W-1:0]       div_q, div_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [ROOM_W-1:0]      room_q, room_d;
  logic [DTH_W-1:0]       dth_q, dth_d;
  logic                   update_q, update_d;
  logic                   div_wrap;
  logic                   tick;
  logic                   consume;
  logic                   spawn;

  assign div_wrap = (div_q == DIV_MAX);

`ifdef FRAME_STEP_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_i;
    end
  end

  assign tick = step_i & ~step_q;
`else
  assign tick = div_wrap;
`endif

  always_comb begin
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
    frame_d  = frame_q + FRAME_CNT_W'(tick);
    state_d  = state_q;
    room_d   = room_q;
    dth_d    = dth_q;
    update_d = 1'b0;
    consume  = 1'b0;
    unique case (state_q)
      SPAWN: begin
        state_d = RUN;
      end
      RUN: begin
        if (exit_i) begin
          state_d = ADVANCE;
        end else if (dead_i) begin
          state_d = DEAD;
          dth_d   = '0;
        end else if (tick) begin
          update_d = 1'b1;
          consume  = 1'b1;
        end
      end
      DEAD: begin
        if (tick) begin
          if (dth_q == DTH_MAX) begin
            state_d = SPAWN;
          end else begin
            dth_d = dth_q + DTH_W'(1);
          end
        end
      end
      ADVANCE: begin
        room_d  = (room_q == ROOM_MAX) ? '0 : room_q + ROOM_W'(1);
        state_d = SPAWN;
      end
      default: begin
        state_d = SPAWN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SPAWN;
      div_q    <= '0;
      frame_q  <= '0;
      room_q   <= '0;
      dth_q    <= '0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
      room_q   <= room_d;
      dth_q    <= dth_d;
      update_q <= update_d;
    end
  end

  assign spawn = (state_q == SPAWN);

  btn_capture u_btn_capture (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn_i),
    .consume_i (consume),
    .clear_i   (spawn),
    .btn_o     (btn_o),
    .btnp_o    (btnp_o)
  );

  assign update_o     = update_q;
  assign player_rst_o = rst | spawn;
  assign room_o       = room_q;
  assign frame_o      = frame_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized scoreboard bench for frame_sequencer with a behavioural
// reference model; small parameters keep frames a few cycles long.
module tb_frame_sequencer;

  localparam int CPF  = 4;
  localparam int NR   = 3;
  localparam int DF   = 2;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  btn_i;
  logic        exit_i;
  logic        dead_i;
  logic        step_i;
  logic        update_o;
  logic        player_rst_o;
  logic [5:0]  btn_o;
  logic [1:0]  btnp_o;
  logic [1:0]  room_o;
  logic [15:0] frame_o;

  always #5 clk = ~clk;

  frame_sequencer #(
    .CLK_PER_FRAME (CPF),
    .NUM_ROOMS     (NR),
    .DEATH_FRAMES  (DF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (btn_i),
    .exit_i       (exit_i),
    .dead_i       (dead_i),
`ifdef FRAME_STEP_EN
    .step_i       (step_i),
`endif
    .update_o     (update_o),
    .player_rst_o (player_rst_o),
    .btn_o        (btn_o),
    .btnp_o       (btnp_o),
    .room_o       (room_o),
    .frame_o      (frame_o)
  );

  typedef struct packed {
    logic        upd;
    logic        prst;
    logic [5:0]  btn;
    logic [1:0]  btnp;
    logic [1:0]  room;
    logic [15:0] frame;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  // Reference model: what the player sees, tracked frame by frame.
  typedef enum {M_SPAWN, M_RUN, M_DEAD, M_ADV} mode_t;
  mode_t       m_mode;
  int          m_clk_in_frame;
  int          m_frames_left;
  int          m_room;
  logic [15:0] m_frame;
  bit          m_jump, m_dash;
  bit          m_prev_jump, m_prev_dash;
  logic [5:0]  m_btn;
  logic [1:0]  m_btnp;
  bit          m_upd;
  bit          m_step_prev;
  int          n_upd, n_wrap;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s cycle=%0d actual=%0h expected=%0h",
                 name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode         = M_SPAWN;
    m_clk_in_frame = 0;
    m_frames_left  = 0;
    m_room         = 0;
    m_frame        = 16'd0;
    m_jump         = 0;
    m_dash         = 0;
    m_prev_jump    = 0;
    m_prev_dash    = 0;
    m_btn          = 6'd0;
    m_btnp         = 2'd0;
    m_upd          = 0;
    m_step_prev    = 0;
  endtask

  task automatic model_step(input bit r, input logic [5:0] b,
                            input bit ex, input bit de, input bit st);
    bit tick, jr, dr, take;
    if (r) begin
      model_reset();
      return;
    end
`ifdef FRAME_STEP_EN
    tick = st && !m_step_prev;
`else
    tick = (m_clk_in_frame == CPF - 1);
`endif
    m_step_prev    = st;
    m_clk_in_frame = (m_clk_in_frame + 1) % CPF;
    if (tick) m_frame = m_frame + 16'd1;
    jr = b[4] && !m_prev_jump;
    dr = b[5] && !m_prev_dash;
    m_prev_jump = b[4];
    m_prev_dash = b[5];
    m_upd = 0;
    take  = 0;
    case (m_mode)
      M_SPAWN: begin
        m_jump = 0;
        m_dash = 0;
        m_mode = M_RUN;
      end
      M_RUN: begin
        if (ex) m_mode = M_ADV;
        else if (de) begin
          m_mode        = M_DEAD;
          m_frames_left = DF;
        end else if (tick) take = 1;
      end
      M_DEAD: begin
        if (tick) begin
          m_frames_left--;
          if (m_frames_left == 0) m_mode = M_SPAWN;
        end
      end
      default: begin
        m_room = (m_room + 1) % NR;
        if (m_room == 0) n_wrap++;
        m_mode = M_SPAWN;
      end
    endcase
    if (take) begin
      m_upd  = 1;
      n_upd++;
      m_btn  = b;
      m_btnp = {m_dash, m_jump};
      m_jump = 0;
      m_dash = 0;
    end
    if (jr) m_jump = 1;
    if (dr) m_dash = 1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty cycle=%0d actual=0 expected=1", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("update_o", update_o, e.upd);
        chk("player_rst_o", player_rst_o, e.prst);
        chk("btn_o", btn_o, e.btn);
        chk("btnp_o", btnp_o, e.btnp);
        chk("room_o", room_o, e.room);
        chk("frame_o", frame_o, e.frame);
      end
    end
  end

  initial begin
    logic [5:0] b;
    bit r, ex, de, st;
    exp_t e;
    rst    = 1'b1;
    btn_i  = 6'd0;
    exit_i = 1'b0;
    dead_i = 1'b0;
    step_i = 1'b0;
    b      = 6'd0;
    n_upd  = 0;
    n_wrap = 0;
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      r  = (c < 3) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 4) == 0)
        b = b ^ (6'd1 << $urandom_range(0, 5));
      ex = ($urandom_range(0, 39) == 0);
      de = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 3) == 0);
      rst    = r;
      btn_i  = b;
      exit_i = ex;
      dead_i = de;
      step_i = st;
      e.upd   = m_upd;
      e.prst  = r || (m_mode == M_SPAWN);
      e.btn   = m_btn;
      e.btnp  = m_btnp;
      e.room  = 2'(m_room);
      e.frame = m_frame;
      sb_q.push_back(e);
      model_step(r, b, ex, de, st);
      mon_en = 1'b1;
    end
    @(posedge clk);
    mon_en = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("model saw %0d updates, %0d room wraps", n_upd, n_wrap);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
